ahb_decode_mux: RTL and testbench
=================================

Name: ahb_decode_mux

Overview:
Parametrised AHB-Lite address decoder plus slave-response multiplexer for the SOPC interconnect. It generalises the fixed three-region decoder to NUM_SLAVES programmable regions. It adds three things the fixed decoder lacks: a registered data-phase select, an integrated default slave that gives a two-cycle ERROR response to unmapped accesses, and a sticky decode-error capture register. It sits between the single AHB master (CPU bridge) and the memory, PIO and APB-bridge slaves.

Parameters:
NUM_SLAVES, 3, number of decoded slave regions (1..8)
DEC_MSB, 31, top haddr bit compared
DEC_LSB, 16, bottom haddr bit compared; region size = 2^DEC_LSB bytes
SLAVE_BASES, {16'h3000,16'h2000,16'h1000}, concatenated region tags, slot i = bits [i*W+W-1 : i*W], W = DEC_MSB-DEC_LSB+1
DATA_W, 32, hrdata width

Ports:
hclk  in  1  AHB clock
hresetn  in  1  asynchronous active-low reset
haddr  in  32  master address (address phase)
htrans  in  2  master transfer type
hready  out  1  muxed HREADY to master; also fed back to all slaves as HREADY input
hresp  out  1  muxed HRESP
hrdata  out  DATA_W  muxed read data
hsel  out  NUM_SLAVES  one-hot address-phase select, combinational
hreadyout_s  in  NUM_SLAVES  per-slave HREADYOUT
hresp_s  in  NUM_SLAVES  per-slave HRESP
hrdata_s  in  NUM_SLAVES*DATA_W  per-slave read data, slot i at [i*DATA_W +: DATA_W]
err_valid  out  1  sticky: an unmapped active transfer occurred
err_addr  out  32  haddr of the first unmapped active transfer
err_clr  in  1  synchronous clear of err_valid and err_addr

Behaviour:
- Clock and reset: single clock hclk. Reset hresetn is asynchronous, active-low.
- Decode: match_i = (haddr[DEC_MSB:DEC_LSB] == tag_i).
  - hsel = lowest-index match only; overlapping tags resolve to the lowest index.
  - hsel is combinational and is driven regardless of htrans. Slaves qualify it with htrans and hready.
- Unmapped: no match and htrans[1]==1 (NONSEQ/SEQ). IDLE/BUSY to an unmapped address are not errors.
- Data-phase select: register dsel[NUM_SLAVES-1:0] plus dflt (default-slave active).
  - Loaded only when hready==1, from hsel and the unmapped flag.
  - Held while hready==0.
  - Reset values: dsel=0, dflt=0.
- Response mux:
  - If dsel has a bit set: hready, hresp and hrdata come from that slave.
  - Else if dflt: responses come from the default-slave FSM, with hrdata=0.
  - Else: hready=1, hresp=0, hrdata=0.
  - Reset outputs: hready=1, hresp=0, hrdata=0, err_valid=0, err_addr=0.
- Default-slave FSM states: D_IDLE, D_ERR1, D_ERR2.
  - D_IDLE outputs hready=1, hresp=0. D_IDLE -> D_ERR1 when hready==1 and an unmapped transfer is present.
  - D_ERR1 outputs hready=0, hresp=1. Always -> D_ERR2.
  - D_ERR2 outputs hready=1, hresp=1. -> D_ERR1 if a new unmapped transfer is present (back-to-back errors), else -> D_IDLE.
  - The address phase that overlaps D_ERR2 is sampled normally, because hready==1 in D_ERR2.
- Latency: a mapped transfer adds zero cycles; the slave's wait states pass straight through. An unmapped transfer costs exactly 2 data-phase cycles.
- Error capture:
  - On an unmapped sample with hready==1 and err_valid==0: err_addr <= haddr and err_valid <= 1.
  - Later errors do not overwrite err_addr.
  - err_clr clears both err_valid and err_addr. If err_clr coincides with a new error, the new error wins: err_valid=1, err_addr=new address.
- Reset mid-transfer: asynchronous return to D_IDLE with dsel=0. hready goes to 1 immediately.
- NUM_SLAVES=1: the decode still checks the tag; every non-matching address routes to the default slave.

Decomposition:
- Shared package/header: AHB HTRANS encodings (IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11), HRESP_OKAY=0, HRESP_ERROR=1, and the SOPC base tags RAM=16'h1000, PIO=16'h2000, APB=16'h3000.
- One natural sub-module, ahb_default_slave: the 3-state FSM with inputs hclk, hresetn, hsel_dflt, hready and outputs hreadyout, hresp.
- Decode, data-phase register and mux stay in the top module.

Test Plan:
1. Reset then NONSEQ read 0x1000_0040, slave0 returns hrdata_s slot0=0xDEAD_BEEF, hreadyout_s=3'b111 -> hsel=3'b001 in the address cycle; next cycle hready=1, hrdata=0xDEAD_BEEF, hresp=0.
2. NONSEQ to 0x2000_0000 with slave1 holding hreadyout low for 3 cycles -> hready=0 for exactly 3 cycles; dsel stays 3'b010; new haddr is ignored until hready=1.
3. NONSEQ to unmapped 0x4000_0010 -> hsel=0; next cycle hready=0, hresp=1; following cycle hready=1, hresp=1; err_valid=1, err_addr=0x4000_0010.
4. Two back-to-back unmapped NONSEQs (0x5000_0000 then 0x6000_0000) -> ERR1, ERR2, ERR1, ERR2 sequence; err_addr stays 0x5000_0000; err_clr pulsed with a third error at 0x7000_0000 -> err_addr=0x7000_0000.
5. IDLE htrans with haddr=0x9000_0000 -> no error, hready=1, hresp=0, err_valid unchanged.
6. Assert hresetn low during D_ERR1 -> hready=1, hresp=0 asynchronously; after release the first mapped transfer to 0x3000_0004 selects hsel=3'b100.

Source files
------------

// File: rtl/ahb_decode_mux_pkg.sv
// Shared AHB-Lite encodings, SOPC region tags and default-slave state type
// for the address decoder / response multiplexer.
package ahb_decode_mux_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [15:0] TAG_RAM = 16'h1000;
    localparam logic [15:0] TAG_PIO = 16'h2000;
    localparam logic [15:0] TAG_APB = 16'h3000;

    typedef enum logic [1:0] {
        D_IDLE = 2'd0,
        D_ERR1 = 2'd1,
        D_ERR2 = 2'd2
    } dflt_state_e;

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: two-cycle ERROR response (wait+ERROR, then ready+ERROR) for
// unmapped transfers; back-to-back errors chain from ERR2 directly to ERR1.
module ahb_default_slave
    import ahb_decode_mux_pkg::*;
(
    input  logic hclk,
    input  logic hresetn,
    input  logic hsel_dflt,
    input  logic hready,
    output logic hreadyout,
    output logic hresp
);

    dflt_state_e state_q, state_d;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q <= D_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        hreadyout = 1'b1;
        hresp     = HRESP_OKAY;
        case (state_q)
            D_IDLE: begin
                if (hready && hsel_dflt) begin
                    state_d = D_ERR1;
                end
            end
            D_ERR1: begin
                hreadyout = 1'b0;
                hresp     = HRESP_ERROR;
                state_d   = D_ERR2;
            end
            D_ERR2: begin
                hresp   = HRESP_ERROR;
                // hreadyout is high here, so a new address phase is sampled now
                state_d = (hready && hsel_dflt) ? D_ERR1 : D_IDLE;
            end
            default: begin
                state_d = D_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/ahb_decode_mux.sv
// AHB-Lite decoder + response mux: combinational hsel, registered data-phase
// select, zero added latency for mapped slaves, sticky capture of unmapped accesses.
module ahb_decode_mux
    import ahb_decode_mux_pkg::*;
#(
    parameter int NUM_SLAVES = 3,
    parameter int DEC_MSB    = 31,
    parameter int DEC_LSB    = 16,
    parameter logic [NUM_SLAVES*(DEC_MSB-DEC_LSB+1)-1:0] SLAVE_BASES = {TAG_APB, TAG_PIO, TAG_RAM},
    parameter int DATA_W     = 32
) (
    input  logic                         hclk,
    input  logic                         hresetn,
    input  logic [31:0]                  haddr,
    input  logic [1:0]                   htrans,
    output logic                         hready,
    output logic                         hresp,
    output logic [DATA_W-1:0]            hrdata,
    output logic [NUM_SLAVES-1:0]        hsel,
    input  logic [NUM_SLAVES-1:0]        hreadyout_s,
    input  logic [NUM_SLAVES-1:0]        hresp_s,
    input  logic [NUM_SLAVES*DATA_W-1:0] hrdata_s,
    output logic                         err_valid,
    output logic [31:0]                  err_addr,
    input  logic                         err_clr
);

    localparam int TAG_W = DEC_MSB - DEC_LSB + 1;

    logic [NUM_SLAVES-1:0] dsel_q, dsel_d;
    logic                  dflt_q, dflt_d;
    logic                  err_valid_q, err_valid_d;
    logic [31:0]           err_addr_q, err_addr_d;
    logic                  unmapped;
    logic                  dflt_hready;
    logic                  dflt_hresp;
    logic                  unused_htrans0;

    assign unused_htrans0 = htrans[0];

    // Lowest-index match wins so overlapping tags resolve deterministically.
    always_comb begin
        logic found;
        found = 1'b0;
        hsel  = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (!found && (haddr[DEC_MSB:DEC_LSB] == SLAVE_BASES[i*TAG_W +: TAG_W])) begin
                hsel[i] = 1'b1;
                found   = 1'b1;
            end
        end
    end

    assign unmapped = (hsel == '0) && htrans[1];

    always_comb begin
        dsel_d = dsel_q;
        dflt_d = dflt_q;
        if (hready) begin
            dsel_d = hsel;
            dflt_d = unmapped;
        end
    end

    always_comb begin
        err_valid_d = err_valid_q;
        err_addr_d  = err_addr_q;
        if (unmapped && hready && (!err_valid_q || err_clr)) begin
            err_valid_d = 1'b1;
            err_addr_d  = haddr;
        end else if (err_clr) begin
            err_valid_d = 1'b0;
            err_addr_d  = '0;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            dsel_q      <= '0;
            dflt_q      <= 1'b0;
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            dsel_q      <= dsel_d;
            dflt_q      <= dflt_d;
            err_valid_q <= err_valid_d;
            err_addr_q  <= err_addr_d;
        end
    end

    assign err_valid = err_valid_q;
    assign err_addr  = err_addr_q;

    ahb_default_slave u_default_slave (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .hsel_dflt (unmapped),
        .hready    (hready),
        .hreadyout (dflt_hready),
        .hresp     (dflt_hresp)
    );

    always_comb begin
        hready = 1'b1;
        hresp  = HRESP_OKAY;
        hrdata = '0;
        if (dsel_q != '0) begin
            for (int i = 0; i < NUM_SLAVES; i++) begin
                if (dsel_q[i]) begin
                    hready = hreadyout_s[i];
                    hresp  = hresp_s[i];
                    hrdata = hrdata_s[i*DATA_W +: DATA_W];
                end
            end
        end else if (dflt_q) begin
            hready = dflt_hready;
            hresp  = dflt_hresp;
        end
    end

endmodule

// File: tb/tb_ahb_decode_mux.sv
// Directed bench for ahb_decode_mux with hand-computed expectations.
module tb_ahb_decode_mux;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hready;
    logic        hresp;
    logic [31:0] hrdata;
    logic [2:0]  hsel;
    logic [2:0]  hreadyout_s;
    logic [2:0]  hresp_s;
    logic [95:0] hrdata_s;
    logic        err_valid;
    logic [31:0] err_addr;
    logic        err_clr;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 hclk = ~hclk;

    ahb_decode_mux dut (
        .hclk        (hclk),
        .hresetn     (hresetn),
        .haddr       (haddr),
        .htrans      (htrans),
        .hready      (hready),
        .hresp       (hresp),
        .hrdata      (hrdata),
        .hsel        (hsel),
        .hreadyout_s (hreadyout_s),
        .hresp_s     (hresp_s),
        .hrdata_s    (hrdata_s),
        .err_valid   (err_valid),
        .err_addr    (err_addr),
        .err_clr     (err_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; drive and sample happen there.
    task automatic tick();
        @(posedge hclk);
        #2;
    endtask

    initial begin
        hresetn     = 1'b0;
        haddr       = 32'h0;
        htrans      = 2'b00;
        hreadyout_s = 3'b111;
        hresp_s     = 3'b000;
        hrdata_s    = {32'h3333_3333, 32'h1111_1111, 32'hDEAD_BEEF};
        err_clr     = 1'b0;
        #12;
        chk("rst_hready", {31'd0, hready}, 32'd1);
        chk("rst_hresp", {31'd0, hresp}, 32'd0);
        chk("rst_hrdata", hrdata, 32'd0);
        chk("rst_err_valid", {31'd0, err_valid}, 32'd0);
        chk("rst_err_addr", err_addr, 32'd0);
        hresetn = 1'b1;
        tick();

        // 1: mapped read to slave0
        haddr = 32'h1000_0040; htrans = 2'b10; #1;
        chk("t1_hsel", {29'd0, hsel}, 32'h1);
        tick();
        haddr = 32'h0; htrans = 2'b00; #1;
        chk("t1_hready", {31'd0, hready}, 32'd1);
        chk("t1_hrdata", hrdata, 32'hDEAD_BEEF);
        chk("t1_hresp", {31'd0, hresp}, 32'd0);
        chk("t1_hsel_idle_addr", {29'd0, hsel}, 32'h0);

        // 2: slave1 with three wait states; pending address must be held
        haddr = 32'h2000_0000; htrans = 2'b10; #1;
        chk("t2_hsel", {29'd0, hsel}, 32'h2);
        tick();
        haddr = 32'h1000_0000; htrans = 2'b10; hreadyout_s = 3'b101; #1;
        chk("t2_wait1_hready", {31'd0, hready}, 32'd0);
        chk("t2_wait1_hrdata", hrdata, 32'h1111_1111);
        tick(); #1;
        chk("t2_wait2_hready", {31'd0, hready}, 32'd0);
        chk("t2_wait2_hrdata", hrdata, 32'h1111_1111);
        tick(); #1;
        chk("t2_wait3_hready", {31'd0, hready}, 32'd0);
        chk("t2_wait3_hrdata", hrdata, 32'h1111_1111);
        tick();
        hreadyout_s = 3'b111; #1;
        chk("t2_done_hready", {31'd0, hready}, 32'd1);
        chk("t2_done_hrdata", hrdata, 32'h1111_1111);
        tick();
        haddr = 32'h0; htrans = 2'b00; #1;
        chk("t2_held_addr_hrdata", hrdata, 32'hDEAD_BEEF);

        // 3: single unmapped access
        haddr = 32'h4000_0010; htrans = 2'b10; #1;
        chk("t3_hsel", {29'd0, hsel}, 32'h0);
        tick();
        haddr = 32'h0; htrans = 2'b00; #1;
        chk("t3_err1_hready", {31'd0, hready}, 32'd0);
        chk("t3_err1_hresp", {31'd0, hresp}, 32'd1);
        chk("t3_err1_hrdata", hrdata, 32'd0);
        chk("t3_err_valid", {31'd0, err_valid}, 32'd1);
        chk("t3_err_addr", err_addr, 32'h4000_0010);
        tick(); #1;
        chk("t3_err2_hready", {31'd0, hready}, 32'd1);
        chk("t3_err2_hresp", {31'd0, hresp}, 32'd1);
        tick(); #1;
        chk("t3_idle_hready", {31'd0, hready}, 32'd1);
        chk("t3_idle_hresp", {31'd0, hresp}, 32'd0);

        // 4: clear, then back-to-back errors, then clear coinciding with a new error
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0; #1;
        chk("t4_clr_valid", {31'd0, err_valid}, 32'd0);
        chk("t4_clr_addr", err_addr, 32'd0);
        haddr = 32'h5000_0000; htrans = 2'b10;
        tick();
        haddr = 32'h6000_0000; htrans = 2'b10; #1;
        chk("t4_a_err1_hready", {31'd0, hready}, 32'd0);
        chk("t4_a_err1_hresp", {31'd0, hresp}, 32'd1);
        chk("t4_a_err_addr", err_addr, 32'h5000_0000);
        tick(); #1;
        chk("t4_a_err2_hready", {31'd0, hready}, 32'd1);
        chk("t4_a_err2_hresp", {31'd0, hresp}, 32'd1);
        tick();
        haddr = 32'h7000_0000; htrans = 2'b10; #1;
        chk("t4_b_err1_hready", {31'd0, hready}, 32'd0);
        chk("t4_b_err1_hresp", {31'd0, hresp}, 32'd1);
        chk("t4_b_err_addr_kept", err_addr, 32'h5000_0000);
        tick();
        err_clr = 1'b1; #1;
        chk("t4_b_err2_hready", {31'd0, hready}, 32'd1);
        chk("t4_b_err2_hresp", {31'd0, hresp}, 32'd1);
        tick();
        err_clr = 1'b0; haddr = 32'h0; htrans = 2'b00; #1;
        chk("t4_c_err_valid", {31'd0, err_valid}, 32'd1);
        chk("t4_c_err_addr", err_addr, 32'h7000_0000);
        chk("t4_c_err1_hready", {31'd0, hready}, 32'd0);
        tick(); tick(); #1;
        chk("t4_c_idle_hresp", {31'd0, hresp}, 32'd0);

        // 5: IDLE to unmapped address is not an error
        haddr = 32'h9000_0000; htrans = 2'b00; #1;
        chk("t5_hsel", {29'd0, hsel}, 32'h0);
        tick(); #1;
        chk("t5_hready", {31'd0, hready}, 32'd1);
        chk("t5_hresp", {31'd0, hresp}, 32'd0);
        chk("t5_err_valid", {31'd0, err_valid}, 32'd1);
        chk("t5_err_addr", err_addr, 32'h7000_0000);

        // 6: asynchronous reset during ERR1, then mapped access to slave2
        haddr = 32'h8000_0000; htrans = 2'b10;
        tick();
        haddr = 32'h0; htrans = 2'b00; #1;
        chk("t6_err1_hready", {31'd0, hready}, 32'd0);
        hresetn = 1'b0; #1;
        chk("t6_rst_hready", {31'd0, hready}, 32'd1);
        chk("t6_rst_hresp", {31'd0, hresp}, 32'd0);
        chk("t6_rst_err_valid", {31'd0, err_valid}, 32'd0);
        #2;
        hresetn = 1'b1;
        tick();
        haddr = 32'h3000_0004; htrans = 2'b10; #1;
        chk("t6_hsel", {29'd0, hsel}, 32'h4);
        tick();
        haddr = 32'h0; htrans = 2'b00; hresp_s = 3'b100; #1;
        chk("t6_hrdata", hrdata, 32'h3333_3333);
        chk("t6_hready", {31'd0, hready}, 32'd1);
        chk("t6_hresp_pass", {31'd0, hresp}, 32'd1);
        hresp_s = 3'b000;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
